// File: rtl/rf_port_arbiter.sv
// rf_port_arbiter
//   Shares the one register-file access port between three requesters:
//   the decoder read path (dec_*), the debug read path (dbg_*) and the
//   writeback write path (wb_*). One access is issued per cycle, in grant
//   order. Writeback has priority, but only for MAX_WR_STREAK consecutive
//   write grants while a read is waiting. The two readers share the
//   remaining grants round-robin.
//
// Handshake (req/gnt):
//   A requester raises req and holds req plus its address/data fields
//   until it sees gnt. gnt is a registered one-cycle pulse in the cycle
//   after the winning arbitration. While gnt is high, that requester's req
//   is ignored, so the requester can drop it without being granted twice.
//   A reader then gets a one-cycle valid pulse two cycles after its gnt,
//   with rs1/rs2 data. The data outputs hold until that reader's next
//   valid.
//
// Ports:
//   clk, rst                 clock and synchronous active-low reset
//   dec_rd_req/rs1/rs2       decoder read request and source addresses
//   dec_rd_gnt/valid/data    decoder grant, return valid and data
//   dbg_*                    same set for the debug reader
//   wb_wr_req/addr/data      writeback request, destination and data
//   wb_wr_gnt                writeback grant
//   RF_*                     register-file port; this block owns it
//   conflict_cnt             saturating count of contended cycles
module rf_port_arbiter #(
    parameter int MAX_WR_STREAK = 4,
    parameter int CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec_rd_req,
    input  logic [4:0]       dec_rs1_addr,
    input  logic [4:0]       dec_rs2_addr,
    output logic             dec_rd_gnt,
    output logic             dec_rd_valid,
    output logic [31:0]      dec_rs1_data,
    output logic [31:0]      dec_rs2_data,
    input  logic             dbg_rd_req,
    input  logic [4:0]       dbg_rs1_addr,
    input  logic [4:0]       dbg_rs2_addr,
    output logic             dbg_rd_gnt,
    output logic             dbg_rd_valid,
    output logic [31:0]      dbg_rs1_data,
    output logic [31:0]      dbg_rs2_data,
    input  logic             wb_wr_req,
    input  logic [4:0]       wb_wr_addr,
    input  logic [31:0]      wb_wr_data,
    output logic             wb_wr_gnt,
    output logic             RF_chip_enable,
    output logic             RF_write_enable,
    output logic [4:0]       RF_rs1_address,
    output logic [4:0]       RF_rs2_address,
    output logic [4:0]       RF_WR_add,
    output logic [31:0]      RF_WriteData,
    input  logic [31:0]      RF_reg1_data,
    input  logic [31:0]      RF_reg2_data,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [3:0] STREAK_LIMIT = 4'(MAX_WR_STREAK);
    localparam logic [3:0] STREAK_SAT   = 4'hF;

    // Arbitration state: rr_ptr 0 = decoder preferred, 1 = debug preferred.
    logic       rr_ptr;
    logic [3:0] wr_streak;

    // Read return pipeline. Stage 1 is the RF access cycle. Stage 2 is the
    // cycle when RF data is present. The zero flags remember x0 sources so
    // that those lanes return 0 whatever the RF drives.
    logic s1_vld, s1_dbg, s1_z1, s1_z2;
    logic s2_vld, s2_dbg, s2_z1, s2_z2;

    logic       elig_dec, elig_dbg, elig_wb, any_rd_elig;
    logic       win_dec, win_dbg, win_wb, win_rd;
    logic       conflict;
    logic [4:0] rd_rs1, rd_rs2;

    always_comb begin
        // A requester whose grant is showing this cycle is still dropping
        // req, so it is masked out.
        elig_dec    = dec_rd_req & ~dec_rd_gnt;
        elig_dbg    = dbg_rd_req & ~dbg_rd_gnt;
        elig_wb     = wb_wr_req  & ~wb_wr_gnt;
        any_rd_elig = elig_dec | elig_dbg;

        win_wb  = elig_wb & ((wr_streak < STREAK_LIMIT) | ~any_rd_elig);
        win_dec = ~win_wb & elig_dec & (~rr_ptr | ~elig_dbg);
        win_dbg = ~win_wb & elig_dbg & ( rr_ptr | ~elig_dec);
        win_rd  = win_dec | win_dbg;

        conflict = (elig_dec & elig_dbg) | (elig_dec & elig_wb) |
                   (elig_dbg & elig_wb);

        rd_rs1 = win_dbg ? dbg_rs1_addr : dec_rs1_addr;
        rd_rs2 = win_dbg ? dbg_rs2_addr : dec_rs2_addr;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dec_rd_gnt      <= 1'b0;
            dbg_rd_gnt      <= 1'b0;
            wb_wr_gnt       <= 1'b0;
            dec_rd_valid    <= 1'b0;
            dbg_rd_valid    <= 1'b0;
            dec_rs1_data    <= '0;
            dec_rs2_data    <= '0;
            dbg_rs1_data    <= '0;
            dbg_rs2_data    <= '0;
            RF_chip_enable  <= 1'b0;
            RF_write_enable <= 1'b0;
            RF_rs1_address  <= '0;
            RF_rs2_address  <= '0;
            RF_WR_add       <= '0;
            RF_WriteData    <= '0;
            conflict_cnt    <= '0;
            rr_ptr          <= 1'b0;
            wr_streak       <= '0;
            s1_vld          <= 1'b0;
            s1_dbg          <= 1'b0;
            s1_z1           <= 1'b0;
            s1_z2           <= 1'b0;
            s2_vld          <= 1'b0;
            s2_dbg          <= 1'b0;
            s2_z1           <= 1'b0;
            s2_z2           <= 1'b0;
        end else begin
            dec_rd_gnt <= win_dec;
            dbg_rd_gnt <= win_dbg;
            wb_wr_gnt  <= win_wb;

            if (win_wb) begin
                // A write to x0 is still a grant, but it never reaches the RF.
                RF_WR_add       <= wb_wr_addr;
                RF_WriteData    <= wb_wr_data;
                RF_chip_enable  <= (wb_wr_addr != 5'd0);
                RF_write_enable <= (wb_wr_addr != 5'd0);
                if (wr_streak != STREAK_SAT) begin
                    wr_streak <= wr_streak + 4'd1;
                end
            end else if (win_rd) begin
                RF_rs1_address  <= rd_rs1;
                RF_rs2_address  <= rd_rs2;
                RF_chip_enable  <= 1'b1;
                RF_write_enable <= 1'b0;
                wr_streak       <= '0;
                rr_ptr          <= win_dec;  // the other reader is preferred next
            end else begin
                RF_chip_enable  <= 1'b0;
                RF_write_enable <= 1'b0;
            end

            s1_vld <= win_rd;
            s1_dbg <= win_dbg;
            s1_z1  <= (rd_rs1 == 5'd0);
            s1_z2  <= (rd_rs2 == 5'd0);
            s2_vld <= s1_vld;
            s2_dbg <= s1_dbg;
            s2_z1  <= s1_z1;
            s2_z2  <= s1_z2;

            dec_rd_valid <= s2_vld & ~s2_dbg;
            dbg_rd_valid <= s2_vld &  s2_dbg;
            if (s2_vld && !s2_dbg) begin
                dec_rs1_data <= s2_z1 ? 32'd0 : RF_reg1_data;
                dec_rs2_data <= s2_z2 ? 32'd0 : RF_reg2_data;
            end
            if (s2_vld && s2_dbg) begin
                dbg_rs1_data <= s2_z1 ? 32'd0 : RF_reg1_data;
                dbg_rs2_data <= s2_z2 ? 32'd0 : RF_reg2_data;
            end

            if (conflict && (conflict_cnt != {CNT_W{1'b1}})) begin
                conflict_cnt <= conflict_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Testbench for rf_port_arbiter. It contains a small register-file model
// that drives RF_reg*_data, a cycle-level reference model that predicts
// every output, directed vector tables and sequences, and a random phase.
module tb_rf_port_arbiter;

  localparam int MAX_WR_STREAK = 4;
  localparam int CNT_W = 16;

  logic clk = 1'b0;
  logic rst;
  logic dec_rd_req, dbg_rd_req, wb_wr_req;
  logic [4:0] dec_rs1_addr, dec_rs2_addr, dbg_rs1_addr, dbg_rs2_addr, wb_wr_addr;
  logic [31:0] wb_wr_data;
  logic dec_rd_gnt, dec_rd_valid, dbg_rd_gnt, dbg_rd_valid, wb_wr_gnt;
  logic [31:0] dec_rs1_data, dec_rs2_data, dbg_rs1_data, dbg_rs2_data;
  logic RF_chip_enable, RF_write_enable;
  logic [4:0] RF_rs1_address, RF_rs2_address, RF_WR_add;
  logic [31:0] RF_WriteData;
  logic [31:0] RF_reg1_data, RF_reg2_data;
  logic [CNT_W-1:0] conflict_cnt;

  rf_port_arbiter #(.MAX_WR_STREAK(MAX_WR_STREAK), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .dec_rd_req(dec_rd_req), .dec_rs1_addr(dec_rs1_addr), .dec_rs2_addr(dec_rs2_addr),
    .dec_rd_gnt(dec_rd_gnt), .dec_rd_valid(dec_rd_valid),
    .dec_rs1_data(dec_rs1_data), .dec_rs2_data(dec_rs2_data),
    .dbg_rd_req(dbg_rd_req), .dbg_rs1_addr(dbg_rs1_addr), .dbg_rs2_addr(dbg_rs2_addr),
    .dbg_rd_gnt(dbg_rd_gnt), .dbg_rd_valid(dbg_rd_valid),
    .dbg_rs1_data(dbg_rs1_data), .dbg_rs2_data(dbg_rs2_data),
    .wb_wr_req(wb_wr_req), .wb_wr_addr(wb_wr_addr), .wb_wr_data(wb_wr_data),
    .wb_wr_gnt(wb_wr_gnt),
    .RF_chip_enable(RF_chip_enable), .RF_write_enable(RF_write_enable),
    .RF_rs1_address(RF_rs1_address), .RF_rs2_address(RF_rs2_address),
    .RF_WR_add(RF_WR_add), .RF_WriteData(RF_WriteData),
    .RF_reg1_data(RF_reg1_data), .RF_reg2_data(RF_reg2_data),
    .conflict_cnt(conflict_cnt)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  // Write-first at the edge; read data appears the cycle after the access.
  logic [31:0] rf_mem [32];
  always @(posedge clk) begin
    if (RF_chip_enable && RF_write_enable) rf_mem[RF_WR_add] = RF_WriteData;
    if (RF_chip_enable && !RF_write_enable) begin
      RF_reg1_data <= rf_mem[RF_rs1_address];
      RF_reg2_data <= rf_mem[RF_rs2_address];
    end
  end

  // ---------------- scoreboard counters ----------------
  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_total++;
    if (act === exp_v) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp_v, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    int          due;
    bit          dbg;
    logic [31:0] d1;
    logic [31:0] d2;
  } ret_t;

  ret_t        ret_q[$];
  logic [31:0] shadow [32];
  bit          model_on = 0;
  int          cyc = 0;
  int          m_ptr = 0;     // 0: decoder preferred, 1: debug preferred
  int          m_streak = 0;
  logic        e_gnt_dec = 0, e_gnt_dbg = 0, e_gnt_wb = 0;
  logic        e_ce = 0, e_we = 0, e_vdec = 0, e_vdbg = 0;
  logic [4:0]  e_rs1 = 0, e_rs2 = 0, e_wa = 0;
  logic [31:0] e_wd = 0, e_dec1 = 0, e_dec2 = 0, e_dbg1 = 0, e_dbg2 = 0;
  logic [15:0] e_cnt = 0;

  always @(negedge clk) begin
    bit ed, eb, ew;
    bit el_rd [2];
    int n_el, win, first, second;
    logic [4:0] a1, a2;
    ret_t r;
    if (model_on) begin
      check("m_dec_gnt", 32'(dec_rd_gnt), 32'(e_gnt_dec));
      check("m_dbg_gnt", 32'(dbg_rd_gnt), 32'(e_gnt_dbg));
      check("m_wb_gnt", 32'(wb_wr_gnt), 32'(e_gnt_wb));
      check("m_ce", 32'(RF_chip_enable), 32'(e_ce));
      check("m_we", 32'(RF_write_enable), 32'(e_we));
      check("m_rs1_addr", 32'(RF_rs1_address), 32'(e_rs1));
      check("m_rs2_addr", 32'(RF_rs2_address), 32'(e_rs2));
      check("m_wr_addr", 32'(RF_WR_add), 32'(e_wa));
      check("m_wr_data", RF_WriteData, e_wd);
      check("m_dec_valid", 32'(dec_rd_valid), 32'(e_vdec));
      check("m_dbg_valid", 32'(dbg_rd_valid), 32'(e_vdbg));
      check("m_dec_rs1", dec_rs1_data, e_dec1);
      check("m_dec_rs2", dec_rs2_data, e_dec2);
      check("m_dbg_rs1", dbg_rs1_data, e_dbg1);
      check("m_dbg_rs2", dbg_rs2_data, e_dbg2);
      check("m_conflict_cnt", 32'(conflict_cnt), 32'(e_cnt));

      if (!rst) begin
        e_gnt_dec = 0; e_gnt_dbg = 0; e_gnt_wb = 0;
        e_ce = 0; e_we = 0; e_vdec = 0; e_vdbg = 0;
        e_rs1 = 0; e_rs2 = 0; e_wa = 0; e_wd = 0;
        e_dec1 = 0; e_dec2 = 0; e_dbg1 = 0; e_dbg2 = 0;
        e_cnt = 0; m_ptr = 0; m_streak = 0;
        ret_q.delete();
      end else begin
        ed = dec_rd_req && !e_gnt_dec;
        eb = dbg_rd_req && !e_gnt_dbg;
        ew = wb_wr_req && !e_gnt_wb;
        n_el = int'(ed) + int'(eb) + int'(ew);
        if (n_el >= 2 && e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;

        el_rd[0] = ed;
        el_rd[1] = eb;
        win = 0;  // 0 none, 1 wb, 2 dec, 3 dbg
        if (ew && (m_streak < MAX_WR_STREAK || !(ed || eb))) win = 1;
        else begin
          first = m_ptr;
          second = 1 - m_ptr;
          if (el_rd[first]) win = 2 + first;
          else if (el_rd[second]) win = 2 + second;
        end

        e_gnt_wb = (win == 1);
        e_gnt_dec = (win == 2);
        e_gnt_dbg = (win == 3);
        if (win == 1) begin
          if (m_streak < 15) m_streak++;
          e_wa = wb_wr_addr;
          e_wd = wb_wr_data;
          e_ce = (wb_wr_addr != 0);
          e_we = e_ce;
          if (wb_wr_addr != 0) shadow[wb_wr_addr] = wb_wr_data;
        end else if (win >= 2) begin
          a1 = (win == 2) ? dec_rs1_addr : dbg_rs1_addr;
          a2 = (win == 2) ? dec_rs2_addr : dbg_rs2_addr;
          e_rs1 = a1;
          e_rs2 = a2;
          e_ce = 1;
          e_we = 0;
          m_streak = 0;
          m_ptr = (win == 2) ? 1 : 0;
          r.due = cyc + 3;
          r.dbg = (win == 3);
          r.d1 = (a1 == 0) ? 32'd0 : shadow[a1];
          r.d2 = (a2 == 0) ? 32'd0 : shadow[a2];
          ret_q.push_back(r);
        end else begin
          e_ce = 0;
          e_we = 0;
        end

        e_vdec = 0;
        e_vdbg = 0;
        if (ret_q.size() != 0 && ret_q[0].due == cyc + 1) begin
          r = ret_q.pop_front();
          if (r.dbg) begin e_vdbg = 1; e_dbg1 = r.d1; e_dbg2 = r.d2; end
          else begin e_vdec = 1; e_dec1 = r.d1; e_dec2 = r.d2; end
        end
      end
      cyc++;
    end
  end

  // ---------------- directed vector table ----------------
  typedef struct {
    int          kind;   // 0 dec read, 1 dbg read, 2 wb write
    logic [4:0]  a1;     // rs1 or write address
    logic [4:0]  a2;
    logic [31:0] wd;
    logic        ce;
    logic        we;
    logic [31:0] d1;
    logic [31:0] d2;
  } vec_t;

  vec_t vecs [6];

  task automatic drop_all();
    dec_rd_req = 0;
    dbg_rd_req = 0;
    wb_wr_req = 0;
  endtask

  task automatic do_reset();
    drop_all();
    rst = 0;
    step();
    step();
    rst = 1;
  endtask

  initial begin
    int n;
    logic vld;
    logic [31:0] d1, d2;

    for (int i = 0; i < 32; i++) begin
      rf_mem[i] = 32'hC000_0000 | 32'(i);
      shadow[i] = 32'hC000_0000 | 32'(i);
    end
    rf_mem[5] = 32'h0000_1234;
    shadow[5] = 32'h0000_1234;
    RF_reg1_data = 0;
    RF_reg2_data = 0;
    rst = 0;
    drop_all();
    dec_rs1_addr = 0; dec_rs2_addr = 0;
    dbg_rs1_addr = 0; dbg_rs2_addr = 0;
    wb_wr_addr = 0; wb_wr_data = 0;

    vecs[0] = '{0, 5'd5, 5'd0, 32'd0, 1'b1, 1'b0, 32'h0000_1234, 32'd0};
    vecs[1] = '{2, 5'd7, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b1, 32'd0, 32'd0};
    vecs[2] = '{0, 5'd7, 5'd5, 32'd0, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0000_1234};
    vecs[3] = '{2, 5'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0, 32'd0};
    vecs[4] = '{1, 5'd0, 5'd7, 32'd0, 1'b1, 1'b0, 32'd0, 32'hDEAD_BEEF};
    vecs[5] = '{1, 5'd31, 5'd3, 32'd0, 1'b1, 1'b0, 32'hC000_001F, 32'hC000_0003};

    step();
    model_on = 1;
    step();
    rst = 1;

    // Reset state
    check("rst_dec_gnt", 32'(dec_rd_gnt), 32'd0);
    check("rst_ce", 32'(RF_chip_enable), 32'd0);
    check("rst_dec_valid", 32'(dec_rd_valid), 32'd0);
    check("rst_dec_rs1", dec_rs1_data, 32'd0);
    check("rst_wr_data", RF_WriteData, 32'd0);
    check("rst_cnt", 32'(conflict_cnt), 32'd0);

    // Isolated transactions from an idle arbiter
    for (int i = 0; i < 6; i++) begin
      if (vecs[i].kind == 0) begin
        dec_rd_req = 1; dec_rs1_addr = vecs[i].a1; dec_rs2_addr = vecs[i].a2;
      end else if (vecs[i].kind == 1) begin
        dbg_rd_req = 1; dbg_rs1_addr = vecs[i].a1; dbg_rs2_addr = vecs[i].a2;
      end else begin
        wb_wr_req = 1; wb_wr_addr = vecs[i].a1; wb_wr_data = vecs[i].wd;
      end
      step();
      check("vec_dec_gnt", 32'(dec_rd_gnt), 32'(vecs[i].kind == 0));
      check("vec_dbg_gnt", 32'(dbg_rd_gnt), 32'(vecs[i].kind == 1));
      check("vec_wb_gnt", 32'(wb_wr_gnt), 32'(vecs[i].kind == 2));
      check("vec_ce", 32'(RF_chip_enable), 32'(vecs[i].ce));
      check("vec_we", 32'(RF_write_enable), 32'(vecs[i].we));
      if (vecs[i].kind == 2) begin
        check("vec_wr_addr", 32'(RF_WR_add), 32'(vecs[i].a1));
        check("vec_wr_data", RF_WriteData, vecs[i].wd);
      end else begin
        check("vec_rs1_addr", 32'(RF_rs1_address), 32'(vecs[i].a1));
        check("vec_rs2_addr", 32'(RF_rs2_address), 32'(vecs[i].a2));
      end
      drop_all();
      step();
      step();
      if (vecs[i].kind != 2) begin
        vld = (vecs[i].kind == 0) ? dec_rd_valid : dbg_rd_valid;
        d1 = (vecs[i].kind == 0) ? dec_rs1_data : dbg_rs1_data;
        d2 = (vecs[i].kind == 0) ? dec_rs2_data : dbg_rs2_data;
        check("vec_valid", 32'(vld), 32'd1);
        check("vec_rs1_data", d1, vecs[i].d1);
        check("vec_rs2_data", d2, vecs[i].d2);
      end
      step();
      step();
    end

    // Write then read of the same register in consecutive cycles
    wb_wr_req = 1; wb_wr_addr = 5'd9; wb_wr_data = 32'h0BAD_F00D;
    step();
    check("wr_rd_wb_gnt", 32'(wb_wr_gnt), 32'd1);
    check("wr_rd_we1", 32'(RF_write_enable), 32'd1);
    wb_wr_req = 0;
    dec_rd_req = 1; dec_rs1_addr = 5'd9; dec_rs2_addr = 5'd7;
    step();
    check("wr_rd_dec_gnt", 32'(dec_rd_gnt), 32'd1);
    check("wr_rd_ce2", 32'(RF_chip_enable), 32'd1);
    check("wr_rd_we2", 32'(RF_write_enable), 32'd0);
    dec_rd_req = 0;
    step();
    step();
    check("wr_rd_valid", 32'(dec_rd_valid), 32'd1);
    check("wr_rd_rs1", dec_rs1_data, 32'h0BAD_F00D);
    check("wr_rd_rs2", dec_rs2_data, 32'hDEAD_BEEF);
    step();

    // Both readers held continuously: grants alternate starting with dec
    do_reset();
    dec_rd_req = 1; dec_rs1_addr = 5'd1; dec_rs2_addr = 5'd2;
    dbg_rd_req = 1; dbg_rs1_addr = 5'd3; dbg_rs2_addr = 5'd4;
    for (int i = 1; i <= 6; i++) begin
      step();
      check("alt_dec_gnt", 32'(dec_rd_gnt), 32'(i % 2));
      check("alt_dbg_gnt", 32'(dbg_rd_gnt), 32'(1 - (i % 2)));
    end
    check("alt_conflict", 32'(conflict_cnt), 32'd1);
    drop_all();
    for (int i = 0; i < 4; i++) step();

    // Write streak limit: after 4 write grants a waiting read wins
    do_reset();
    wb_wr_req = 1; wb_wr_addr = 5'd10; wb_wr_data = 32'h5555_AAAA;
    n = 0;
    for (int i = 0; i < 20 && n < 4; i++) begin
      step();
      if (wb_wr_gnt) n++;
    end
    check("streak_wb_grants", 32'(n), 32'd4);
    step();
    dec_rd_req = 1; dec_rs1_addr = 5'd10; dec_rs2_addr = 5'd0;
    step();
    check("streak_dec_gnt", 32'(dec_rd_gnt), 32'd1);
    check("streak_wb_held", 32'(wb_wr_gnt), 32'd0);
    dec_rd_req = 0;
    step();
    check("streak_wb_resume", 32'(wb_wr_gnt), 32'd1);
    drop_all();
    for (int i = 0; i < 4; i++) step();

    // Reset right after a decoder grant: the read never returns
    dec_rd_req = 1; dec_rs1_addr = 5'd5; dec_rs2_addr = 5'd5;
    step();
    check("rflush_gnt", 32'(dec_rd_gnt), 32'd1);
    dec_rd_req = 0;
    step();
    rst = 0;
    step();
    check("rflush_valid", 32'(dec_rd_valid), 32'd0);
    check("rflush_rs1", dec_rs1_data, 32'd0);
    check("rflush_ce", 32'(RF_chip_enable), 32'd0);
    check("rflush_cnt", 32'(conflict_cnt), 32'd0);
    rst = 1;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (dec_rd_valid) n++;
    end
    check("rflush_no_valid", 32'(n), 32'd0);
    dec_rd_req = 1; dbg_rd_req = 1;
    step();
    check("rflush_ptr_dec", 32'(dec_rd_gnt), 32'd1);
    check("rflush_ptr_dbg", 32'(dbg_rd_gnt), 32'd0);
    dec_rd_req = 0;
    step();
    check("rflush_dbg_next", 32'(dbg_rd_gnt), 32'd1);
    drop_all();
    for (int i = 0; i < 4; i++) step();

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end
      if (dec_rd_req && dec_rd_gnt) dec_rd_req = 0;
      if (dbg_rd_req && dbg_rd_gnt) dbg_rd_req = 0;
      if (wb_wr_req && wb_wr_gnt) wb_wr_req = 0;
      if (!dec_rd_req && $urandom_range(0, 99) < 30) begin
        dec_rd_req = 1;
        dec_rs1_addr = 5'($urandom_range(0, 31));
        dec_rs2_addr = 5'($urandom_range(0, 31));
      end
      if (!dbg_rd_req && $urandom_range(0, 99) < 30) begin
        dbg_rd_req = 1;
        dbg_rs1_addr = 5'($urandom_range(0, 31));
        dbg_rs2_addr = 5'($urandom_range(0, 31));
      end
      if (!wb_wr_req && $urandom_range(0, 99) < 40) begin
        wb_wr_req = 1;
        wb_wr_addr = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_wr_data = $urandom;
      end
      step();
    end

    drop_all();
    for (int i = 0; i < 8; i++) step();
    check("drain_queue_empty", 32'(ret_q.size()), 32'd0);
    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/rf_port_arbiter.md
Name: rf_port_arbiter

Overview:
- Shares the single register-file access port between three requesters: the decoder read path, the debug read path and the writeback write path.
- Serializes all accesses, one per cycle, so that program-order write-then-read is preserved.
- Writeback has priority, bounded by an anti-starvation streak limit; the two read requesters are round-robined.
- Sits between decode/writeback/debug and the RF, and owns all RF_* control signals.

Parameters:
MAX_WR_STREAK, 4, consecutive write grants allowed while a read is pending (range 1..15)
CNT_W, 16, width of the saturating conflict counter

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
dec_rd_req  in  1  decoder read request; held with addresses until dec_rd_gnt
dec_rs1_addr  in  5  decoder source register 1
dec_rs2_addr  in  5  decoder source register 2
dec_rd_gnt  out  1  one-cycle grant pulse
dec_rd_valid  out  1  one-cycle pulse, dec_rs*_data valid
dec_rs1_data  out  32  rs1 value
dec_rs2_data  out  32  rs2 value
dbg_rd_req, dbg_rs1_addr, dbg_rs2_addr, dbg_rd_gnt, dbg_rd_valid, dbg_rs1_data, dbg_rs2_data  (same directions, widths and meaning as dec_*, debug requester)
wb_wr_req  in  1  writeback request; held with addr/data until wb_wr_gnt
wb_wr_addr  in  5  destination register
wb_wr_data  in  32  write data
wb_wr_gnt  out  1  one-cycle grant pulse
RF_chip_enable  out  1  RF access this cycle
RF_write_enable  out  1  1 = write, 0 = read
RF_rs1_address  out  5  RF read address 1
RF_rs2_address  out  5  RF read address 2
RF_WR_add  out  5  RF write address
RF_WriteData  out  32  RF write data
RF_reg1_data  in  32  RF read data 1, valid the cycle after a read access
RF_reg2_data  in  32  RF read data 2
conflict_cnt  out  CNT_W  saturating count of cycles in which one or more requests lost arbitration

Behaviour:
- Reset (rst=0 at a clock edge):
  - All outputs go to 0.
  - rr_ptr = decoder, wr_streak = 0.
  - The in-flight read pipeline is flushed; no valid pulse follows a pre-reset grant.
- Arbitration (cycle N):
  - Eligible requests are the req inputs, each masked if that requester's gnt is high in cycle N. This blocks re-grant while the requester is still dropping req.
  - Priority rule 1: wb wins if eligible and either (wr_streak < MAX_WR_STREAK) or no read is eligible.
  - Priority rule 2: otherwise the eligible reader selected by rr_ptr wins, or the other reader if that one is not eligible.
- Grant registration (edge end of N), effective in cycle N+1:
  - The winner's gnt is high for exactly one cycle.
  - RF_chip_enable=1, and the RF_* address/data fields are loaded from the winner.
  - With no winner: RF_chip_enable=0 and RF_write_enable=0. The address/data fields hold their last values.
- Write grant:
  - RF_write_enable=1 and wr_streak increments, saturating at 15.
  - If wb_wr_addr==0: wb_wr_gnt still pulses, but RF_chip_enable=0 and RF_write_enable=0 (x0 write suppressed). This still counts as a write grant.
- Read grant:
  - RF_write_enable=0, wr_streak is cleared, and rr_ptr toggles to the other reader.
- Read return:
  - RF data is sampled in cycle N+2.
  - In cycle N+3 the granted reader's rs1/rs2 data outputs are registered and its valid pulses for 1 cycle.
  - A source address of 0 returns 0 regardless of RF data.
  - Data outputs hold until the next valid for that requester.
  - Reader-to-reader pipelining is allowed: back-to-back read grants on alternating cycles give back-to-back valid pulses.
- Ordering:
  - Accesses reach the RF strictly in grant order.
  - A read granted after a write to the same register returns the new value; the RF is write-first at the edge.
- conflict_cnt: increments in any cycle where at least 2 eligible requests exist. It saturates at all-ones and clears only on reset.
- Protocol violations: deasserting req before gnt is not allowed. The arbiter does not need to detect it, but it must not grant a requester whose req was low at its arbitration cycle.
- Latency figures:
  - Idle arbiter, single request: gnt 1 cycle after req.
  - Read data valid 3 cycles after req.

Test Plan:
- Single decoder read, rs1=5 (RF=0x1234), rs2=0 -> dec_rd_gnt in cycle 1; dec_rd_valid in cycle 3 with rs1=0x1234, rs2=0; RF_write_enable=0.
- wb write x7=0xDEADBEEF, then decoder read of x7 the next cycle -> RF write then RF read in consecutive cycles; dec_rs1_data=0xDEADBEEF.
- dec and dbg held continuously, no wb -> grants alternate dec, dbg, dec…; each valid is 2 cycles after its gnt; conflict_cnt increments every arbitration cycle with both eligible.
- wb held continuously plus dec pending, MAX_WR_STREAK=4 -> 4 wb grants, then 1 dec grant, then wb resumes; streak counter resets.
- wb write to x0 with data 0xFFFFFFFF -> wb_wr_gnt pulses; RF_chip_enable and RF_write_enable stay 0; a subsequent read of x0 returns 0.
- rst driven low the cycle after a dec grant -> all outputs 0 next cycle; no dec_rd_valid ever appears for that grant; after release, rr_ptr starts at decoder.
